// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: walks a codec register-write table and issues one 3-byte I2C frame per entry,
// with NACK retries, an inter-frame gap and sticky status. Optional power-up delay: I2C_SEQ_PWRUP_DELAY_EN.
module i2c_cmd_sequencer #(
   parameter int         NUM_CMDS     = 16,
   parameter logic [6:0] DEV_ADDR     = 7'h3B,
   parameter int         GAP_CYCLES   = 100,
   parameter int         MAX_RETRIES  = 3,
   parameter int         PWRUP_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [7:0]  err_idx_o,
   output logic [7:0]  tbl_addr_o,
   input  logic [23:0] tbl_data_i,
   output logic        m_valid_o,
   input  logic        m_ready_i,
   output logic [6:0]  m_dev_o,
   output logic [23:0] m_data_o,
   input  logic        m_done_i,
   input  logic        m_ack_i
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [7:0]       LAST_IDX = 8'(NUM_CMDS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(32'd0);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(32'd1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
   localparam logic [RTY_W-1:0] RTY_ZERO = RTY_W'(32'd0);
   localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(32'd1);

   if (NUM_CMDS < 1 || NUM_CMDS > 256 || GAP_CYCLES < 1 || MAX_RETRIES < 0 || PWRUP_CYCLES < 1) begin : g_bad_params
      $error("i2c_cmd_sequencer: parameter out of range");
   end

`ifdef I2C_SEQ_PWRUP_DELAY_EN
   localparam int PWR_W = $clog2(PWRUP_CYCLES + 1);
   localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYCLES - 1);
   localparam logic [PWR_W-1:0] PWR_ZERO = PWR_W'(32'd0);
   localparam logic [PWR_W-1:0] PWR_ONE  = PWR_W'(32'd1);
   logic [PWR_W-1:0] pwr_r, pwr_s;
`endif

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_LATCH     = 4'd2,
      ST_ISSUE     = 4'd3,
      ST_WAIT_DONE = 4'd4,
      ST_GAP       = 4'd5,
      ST_DONE      = 4'd6,
      ST_ERROR     = 4'd7
`ifdef I2C_SEQ_PWRUP_DELAY_EN
      , ST_PWRUP   = 4'd8
`endif
   } state_t;

   state_t           state_r, state_s;
   logic [7:0]       idx_r, idx_s;
   logic [RTY_W-1:0] rty_r, rty_s;
   logic [GAP_W-1:0] gap_r, gap_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             error_r, error_s;
   logic [7:0]       err_idx_r, err_idx_s;
   logic [7:0]       tbl_addr_r, tbl_addr_s;
   logic             m_valid_r, m_valid_s;
   logic [23:0]      m_data_r, m_data_s;

   // state and datapath registers, all cleared by the synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         idx_r      <= 8'd0;
         rty_r      <= RTY_ZERO;
         gap_r      <= GAP_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         err_idx_r  <= 8'd0;
         tbl_addr_r <= 8'd0;
         m_valid_r  <= 1'b0;
         m_data_r   <= 24'd0;
`ifdef I2C_SEQ_PWRUP_DELAY_EN
         pwr_r      <= PWR_ZERO;
`endif
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         rty_r      <= rty_s;
         gap_r      <= gap_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         error_r    <= error_s;
         err_idx_r  <= err_idx_s;
         tbl_addr_r <= tbl_addr_s;
         m_valid_r  <= m_valid_s;
         m_data_r   <= m_data_s;
`ifdef I2C_SEQ_PWRUP_DELAY_EN
         pwr_r      <= pwr_s;
`endif
      end
   end

   // next-state and next-output logic; every register holds unless a state changes it
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      rty_s      = rty_r;
      gap_s      = gap_r;
      busy_s     = busy_r;
      done_s     = done_r;
      error_s    = error_r;
      err_idx_s  = err_idx_r;
      tbl_addr_s = tbl_addr_r;
      m_valid_s  = m_valid_r;
      m_data_s   = m_data_r;
`ifdef I2C_SEQ_PWRUP_DELAY_EN
      pwr_s      = pwr_r;
`endif
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               done_s     = 1'b0;
               error_s    = 1'b0;
               err_idx_s  = 8'd0;
               idx_s      = 8'd0;
               rty_s      = RTY_ZERO;
               busy_s     = 1'b1;
               tbl_addr_s = 8'd0;
`ifdef I2C_SEQ_PWRUP_DELAY_EN
               pwr_s      = PWR_ZERO;
               state_s    = ST_PWRUP;
`else
               state_s    = ST_FETCH;
`endif
            end else begin
               state_s = state_r;
            end
         end
`ifdef I2C_SEQ_PWRUP_DELAY_EN
         ST_PWRUP: begin
            if (pwr_r == PWR_LAST) begin
               state_s = ST_FETCH;
            end else begin
               pwr_s = pwr_r + PWR_ONE;
            end
         end
`endif
         ST_FETCH: begin
            state_s = ST_LATCH;
         end
         // ROM data for tbl_addr_o is valid one cycle after FETCH
         ST_LATCH: begin
            m_data_s  = tbl_data_i;
            m_valid_s = 1'b1;
            state_s   = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (m_ready_i) begin
               m_valid_s = 1'b0;
               state_s   = ST_WAIT_DONE;
            end else begin
               m_valid_s = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (m_done_i) begin
               gap_s = GAP_ZERO;
               if (m_ack_i) begin
                  rty_s   = RTY_ZERO;
                  state_s = ST_GAP;
               end else if (rty_r < RTY_MAX) begin
                  rty_s   = rty_r + RTY_ONE;
                  state_s = ST_GAP;
               end else begin
                  err_idx_s = idx_r;
                  error_s   = 1'b1;
                  busy_s    = 1'b0;
                  state_s   = ST_ERROR;
               end
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         // a non-zero retry count means the last frame was NACKed and is re-issued as latched
         ST_GAP: begin
            if (gap_r == GAP_LAST) begin
               if (rty_r != RTY_ZERO) begin
                  m_valid_s = 1'b1;
                  state_s   = ST_ISSUE;
               end else if (idx_r == LAST_IDX) begin
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
                  state_s = ST_DONE;
               end else begin
                  idx_s      = idx_r + 8'd1;
                  tbl_addr_s = idx_r + 8'd1;
                  state_s    = ST_FETCH;
               end
            end else begin
               gap_s = gap_r + GAP_ONE;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            busy_s    = 1'b0;
            m_valid_s = 1'b0;
         end
      endcase
   end

   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign error_o    = error_r;
   assign err_idx_o  = err_idx_r;
   assign tbl_addr_o = tbl_addr_r;
   assign m_valid_o  = m_valid_r;
   assign m_data_o   = m_data_r;
   assign m_dev_o    = DEV_ADDR;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: scenario table plus random runs against a frame-list model,
// with a scripted reset/restart sequence and a responder modelling the byte-level I2C master.
module tb_i2c_cmd_sequencer;

   localparam int NCMD  = 4;
   localparam int GAP   = 8;
   localparam int MAXR  = 3;
   localparam int PWRUP = 50;
`ifdef I2C_SEQ_PWRUP_DELAY_EN
   localparam int EXP_LAT = PWRUP + 3;
`else
   localparam int EXP_LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b1, start_i = 1'b0;
   logic        busy_o, done_o, error_o;
   logic [7:0]  err_idx_o, tbl_addr_o;
   logic [23:0] tbl_data_i = 24'd0;
   logic        m_valid_o, m_ready_i = 1'b0;
   logic [6:0]  m_dev_o;
   logic [23:0] m_data_o;
   logic        m_done_i = 1'b0, m_ack_i = 1'b0;

   i2c_cmd_sequencer #(.NUM_CMDS(NCMD), .DEV_ADDR(7'h3B), .GAP_CYCLES(GAP),
                       .MAX_RETRIES(MAXR), .PWRUP_CYCLES(PWRUP)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .error_o(error_o), .err_idx_o(err_idx_o), .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_dev_o(m_dev_o), .m_data_o(m_data_o),
      .m_done_i(m_done_i), .m_ack_i(m_ack_i));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][2:0] nacks;
      int rdy_dly;
      int done_dly;
      bit stray;
      bit mid_start;
      int exp_frames;
      bit exp_done;
      bit exp_err;
      int exp_idx;
   } scen_t;

   logic [23:0] rom [NCMD];
   logic [23:0] exp_q[$];
   logic [23:0] obs_q[$];
   int checks = 0, errors = 0;
   int cyc = 0, viol = 0, min_gap = 0, last_done_cyc = 0, max_addr = 0;
   bit have_done = 1'b0;
   int cfg_rdy = 0, cfg_done = 1;
   bit cfg_stray = 1'b0, stray_used = 1'b0;
   int nack_left [NCMD];

   // synchronous table ROM, one-cycle read latency
   always @(posedge clk) tbl_data_i <= rom[tbl_addr_o[1:0]];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic chk_h(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %06h required %06h", nm, act, exp);
      end
   endtask

   function automatic int find_cmd(input logic [23:0] d);
      for (int k = 0; k < NCMD; k++) if (rom[k] == d) return k;
      return -1;
   endfunction

   // Reference: each command is attempted nacks+1 times; more NACKs than MAXR aborts at that command.
   task automatic model(input scen_t s, output scen_t m);
      int n;
      m = s;
      exp_q.delete();
      m.exp_err = 1'b0;
      m.exp_idx = 0;
      for (int i = 0; i < NCMD; i++) begin
         n = int'(s.nacks[i]);
         for (int a = 0; a < ((n > MAXR) ? MAXR + 1 : n + 1); a++) exp_q.push_back(rom[i]);
         if (n > MAXR) begin
            m.exp_err = 1'b1;
            m.exp_idx = i;
            break;
         end
      end
      m.exp_done   = !m.exp_err;
      m.exp_frames = exp_q.size();
   endtask

   // master responder and protocol monitor, both working on the falling edge
   initial begin
      logic p_valid, p_ready, acc;
      logic [23:0] p_data;
      int wcnt, dcnt, k;
      logic d_ack;
      p_valid = 1'b0; p_ready = 1'b0; p_data = 24'd0;
      wcnt = 0; dcnt = -1; d_ack = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         acc = p_valid && p_ready;
         if (acc) begin
            if (m_valid_o) viol++;
            obs_q.push_back(p_data);
            k = find_cmd(p_data);
            if (k >= 0 && nack_left[k] > 0) begin
               d_ack = 1'b0;
               nack_left[k]--;
            end else begin
               d_ack = 1'b1;
            end
            dcnt = cfg_done;
         end else if (p_valid) begin
            if (!m_valid_o || m_data_o !== p_data) viol++;
         end
         if (m_valid_o && !p_valid && have_done && (cyc - last_done_cyc) < min_gap)
            min_gap = cyc - last_done_cyc;
         if (m_valid_o && m_dev_o !== 7'h3B) viol++;
         if (int'(tbl_addr_o) > max_addr) max_addr = int'(tbl_addr_o);
         m_done_i = 1'b0;
         m_ack_i  = 1'b0;
         if (dcnt == 0) begin
            m_done_i = 1'b1;
            m_ack_i  = d_ack;
            dcnt = -1;
            last_done_cyc = cyc;
            have_done = 1'b1;
         end else if (dcnt > 0) begin
            dcnt--;
         end
         if (m_valid_o) begin
            if (wcnt < cfg_rdy) begin
               m_ready_i = 1'b0;
               wcnt++;
               if (cfg_stray && !stray_used && wcnt == 5) begin
                  m_done_i = 1'b1;
                  m_ack_i  = 1'b0;
                  stray_used = 1'b1;
               end
            end else begin
               m_ready_i = 1'b1;
               wcnt = 0;
            end
         end else begin
            m_ready_i = 1'b0;
            wcnt = 0;
         end
         p_valid = m_valid_o;
         p_ready = m_ready_i;
         p_data  = m_data_o;
      end
   end

   task automatic run_scen(input string nm, input scen_t s);
      scen_t m;
      int lat, n, last;
      bit mid_done;
      model(s, m);
      for (int i = 0; i < NCMD; i++) nack_left[i] = int'(s.nacks[i]);
      cfg_rdy = s.rdy_dly; cfg_done = s.done_dly; cfg_stray = s.stray; stray_used = 1'b0;
      obs_q.delete();
      viol = 0; min_gap = 1000000; have_done = 1'b0; max_addr = 0;
      start_i = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start_i = 1'b0;
            chk({nm, "_busy_on"}, int'(busy_o), 1);
         end
      end while (!m_valid_o && lat < 200);
      chk({nm, "_latency"}, lat, EXP_LAT);
      n = 0;
      mid_done = 1'b0;
      while (busy_o && n < 5000) begin
         @(negedge clk);
         n++;
         if (s.mid_start && !mid_done && obs_q.size() == 2) begin
            start_i = 1'b1;
            mid_done = 1'b1;
         end else begin
            start_i = 1'b0;
         end
      end
      chk({nm, "_timeout"}, int'(n < 5000), 1);
      repeat (30) @(negedge clk);
      chk({nm, "_frames"}, obs_q.size(), s.exp_frames);
      if (obs_q.size() == exp_q.size())
         foreach (exp_q[i]) chk_h({nm, "_payload"}, obs_q[i], exp_q[i]);
      chk({nm, "_done"}, int'(done_o), int'(s.exp_done));
      chk({nm, "_error"}, int'(error_o), int'(s.exp_err));
      chk({nm, "_err_idx"}, int'(err_idx_o), s.exp_err ? s.exp_idx : 0);
      chk({nm, "_busy_off"}, int'(busy_o), 0);
      chk({nm, "_valid_off"}, int'(m_valid_o), 0);
      chk({nm, "_protocol"}, viol, 0);
      if (obs_q.size() > 1) chk({nm, "_gap"}, int'(min_gap >= GAP), 1);
      last = s.exp_err ? s.exp_idx : NCMD - 1;
      chk({nm, "_max_addr"}, max_addr, last);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, int'(busy_o), 0);
      chk({nm, "_done"}, int'(done_o), 0);
      chk({nm, "_error"}, int'(error_o), 0);
      chk({nm, "_valid"}, int'(m_valid_o), 0);
      chk({nm, "_err_idx"}, int'(err_idx_o), 0);
      chk({nm, "_tbl_addr"}, int'(tbl_addr_o), 0);
      chk_h({nm, "_m_data"}, m_data_o, 24'h000000);
   endtask

   task automatic load_nominal_rom();
      rom[0] = 24'h400001; rom[1] = 24'h4015A5; rom[2] = 24'h401CFF; rom[3] = 24'h40F901;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      scen_t tbl [5];
      scen_t r, m;
      int n;
      logic [31:0] t;
      tbl[0] = '{12'h000, 0, 2, 1'b0, 1'b0, 4, 1'b1, 1'b0, 0};   // nominal
      tbl[1] = '{12'h080, 1, 3, 1'b0, 1'b0, 6, 1'b1, 1'b0, 0};   // cmd 2 NACKed twice
      tbl[2] = '{12'h020, 0, 1, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1};   // cmd 1 NACKed 4 times
      tbl[3] = '{12'h000, 20, 2, 1'b1, 1'b0, 4, 1'b1, 1'b0, 0};  // backpressure + stray done
      tbl[4] = '{12'h000, 2, 4, 1'b0, 1'b1, 4, 1'b1, 1'b0, 0};   // start while busy
      load_nominal_rom();
      for (int i = 0; i < NCMD; i++) nack_left[i] = 0;

      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_i = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_scen($sformatf("scen%0d", i), tbl[i]);

      // reset during WAIT_DONE of command 2, with start_i colliding with reset
      cfg_rdy = 0; cfg_done = 30; cfg_stray = 1'b0;
      for (int i = 0; i < NCMD; i++) nack_left[i] = 0;
      obs_q.delete();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (obs_q.size() < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rst_wait_timeout", int'(n < 2000), 1);
      chk("rst_pre_idx", int'(tbl_addr_o), 2);
      rst_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_mid");
      rst_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      chk("rst_start_ignored", int'(busy_o), 0);
      repeat (40) @(negedge clk);
      chk("rst_late_done_frames", obs_q.size(), 3);
      chk("rst_late_done_busy", int'(busy_o), 0);
      chk("rst_late_done_valid", int'(m_valid_o), 0);
      chk("rst_late_done_flag", int'(done_o), 0);
      run_scen("restart", tbl[0]);

      // random tables, NACK plans and master timing
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NCMD; i++) begin
            t = $urandom();
            rom[i] = {t[23:10], 2'(i), t[7:0]};
         end
         r.nacks = 12'h000;
         for (int i = 0; i < NCMD; i++)
            r.nacks[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
         r.rdy_dly = $urandom_range(0, 3);
         r.done_dly = $urandom_range(0, 4);
         r.stray = 1'b0;
         r.mid_start = 1'b0;
         model(r, m);
         run_scen($sformatf("rand%0d", it), m);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Walks a table of codec register writes and issues each one to the byte-level I2C master as one 3-byte frame: reg addr[15:8], reg addr[7:0], data[7:0].
- Handles NACK retries, an inter-command gap and sticky status.
- Sits between the TL-UL register front end of the audio init block (start/status) and the I2C master driving sda/scl.

Parameters:
- NUM_CMDS, 16: number of table entries, 1..256.
- DEV_ADDR, 7'h3B: 7-bit I2C device address placed on every frame.
- GAP_CYCLES, 100: idle clk cycles between frames, >=1.
- MAX_RETRIES, 3: re-issues of a NACKed frame before abort.
- PWRUP_CYCLES, 1000: pre-sequence delay (optional feature only).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  one-cycle start pulse from the register front end
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky: all commands ACKed
- error_o  out  1  sticky: aborted after retries exhausted
- err_idx_o  out  8  index of the failing command
- tbl_addr_o  out  8  table index
- tbl_data_i  in  24  {reg_addr[15:0], data[7:0]}; synchronous ROM, 1-cycle read latency
- m_valid_o  out  1  frame request to the I2C master
- m_ready_i  in  1  master accepts the frame
- m_dev_o  out  7  device address (= DEV_ADDR)
- m_data_o  out  24  frame payload
- m_done_i  in  1  one-cycle pulse: frame finished
- m_ack_i  in  1  valid with m_done_i; 1 = all bytes ACKed

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. All state is cleared on the first clk_i edge with rst_i=1.
- Reset values:
  - busy_o, done_o, error_o, m_valid_o = 0.
  - err_idx_o, tbl_addr_o, m_data_o = 0.
  - State = IDLE.
- Reset mid-frame: m_valid_o drops on the reset edge. The master is not notified. Any later m_done_i is ignored because the FSM is in IDLE.
- State machine:
  - IDLE/DONE/ERROR + start_i → clear done_o, error_o, err_idx_o, idx, retry count; busy_o=1; go to FETCH.
  - FETCH: tbl_addr_o=idx; go to LATCH.
  - LATCH: capture tbl_data_i into m_data_o (one cycle after the address); go to ISSUE.
  - ISSUE: m_valid_o=1; m_data_o and m_dev_o stable. On m_ready_i=1: m_valid_o=0 on the next edge; go to WAIT_DONE.
  - WAIT_DONE: wait for m_done_i. m_done_i is sampled only in this state; a pulse in any other state is ignored.
    - m_ack_i=1 → retry count=0; go to GAP.
    - m_ack_i=0, retry count < MAX_RETRIES → retry count++; go to GAP, then re-ISSUE the same frame with no refetch.
    - m_ack_i=0, retry count = MAX_RETRIES → err_idx_o=idx; error_o=1; busy_o=0; go to ERROR.
  - GAP: count GAP_CYCLES cycles. Then:
    - retry pending → ISSUE;
    - else idx = NUM_CMDS-1 → done_o=1, busy_o=0, go to DONE;
    - else idx++ and go to FETCH.
  - DONE/ERROR: hold the flags until the next start_i.
- Timing:
  - start_i to first m_valid_o = 3 cycles (FETCH, LATCH, ISSUE).
  - start_i while busy_o=1 is ignored.
- Handshake: valid/ready. m_valid_o is never withdrawn before m_ready_i. Payload does not change while m_valid_o=1.
- Counters:
  - idx is 8-bit and never wraps past NUM_CMDS-1.
  - Gap counter width is $clog2(GAP_CYCLES+1).
  - Retry counter width is $clog2(MAX_RETRIES+1).
- Simultaneous rst_i and start_i: reset wins.

Optional Feature:
- Macro: I2C_SEQ_PWRUP_DELAY_EN.
- Defined: adds a PWRUP state entered from start_i. It waits PWRUP_CYCLES cycles before FETCH, so the first m_valid_o appears at start_i + PWRUP_CYCLES + 3. busy_o=1 during PWRUP. Codec power-up settling.
- Undefined: PWRUP state and its counter are absent; start_i goes straight to FETCH.

Test Plan:
- Nominal sequence. Setup: NUM_CMDS=4, table {400001, 4015A5, 401CFF, 40F901}, master always ACKs. Required:
  - 4 frames with m_dev_o=3B and those payloads in order;
  - frame gaps >= GAP_CYCLES;
  - done_o=1, busy_o=0, error_o=0 at the end.
- Retry recovers. Master NACKs command 2 twice, then ACKs → payload 401CFF is issued 3 times; sequence completes with done_o=1.
- Retries exhausted. Master NACKs command 1 for MAX_RETRIES+1=4 attempts → error_o=1, err_idx_o=1, busy_o=0, no further frames, command 2 never fetched.
- Backpressure and stray done. Setup: m_ready_i held 0 for 20 cycles; m_done_i pulsed during ISSUE. Required:
  - m_valid_o and m_data_o stable for all 20 cycles;
  - the stray pulse is ignored;
  - accept occurs when m_ready_i rises.
- Reset and restart.
  - rst_i asserted during WAIT_DONE of command 2 → next edge all outputs 0 and state IDLE.
  - start_i during busy is ignored.
  - New start_i after reset restarts from index 0.
- Macro defined, PWRUP_CYCLES=50 → first m_valid_o exactly 53 cycles after start_i.
